// File: rtl/crypto_load_sequencer.sv
// Load sequencer ahead of the crypto core: stages key/block words, starts the core, holds its result.
// Optional build macro LOADSEQ_KEY_ZEROIZE_EN wipes key staging after every run and on clr.
module crypto_load_sequencer #(
  parameter int WORD_W      = 32,
  parameter int KEY_WORDS   = 8,
  parameter int DATA_WORDS  = 4,
  parameter int TIMEOUT_CYC = 24
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic                         wr_sel,
  input  logic [WORD_W-1:0]            wr_data,
  input  logic                         clr,
  output logic                         core_start,
  output logic [WORD_W*KEY_WORDS-1:0]  core_key,
  output logic [WORD_W*DATA_WORDS-1:0] core_data,
  input  logic                         core_valid,
  input  logic [127:0]                 core_result,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [127:0]                 res_data,
  output logic                         busy,
  output logic                         err_ovf,
  output logic                         err_tmo
);

  localparam int KCW = $clog2(KEY_WORDS + 1);
  localparam int DCW = $clog2(DATA_WORDS + 1);
  localparam int TCW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [KCW-1:0] KEY_FULL  = KCW'(KEY_WORDS);
  localparam logic [KCW-1:0] KEY_LAST  = KCW'(KEY_WORDS - 1);
  localparam logic [DCW-1:0] DATA_FULL = DCW'(DATA_WORDS);
  localparam logic [DCW-1:0] DATA_LAST = DCW'(DATA_WORDS - 1);
  localparam logic [TCW-1:0] TMO_LAST  = TCW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_OUT
  } state_t;

  state_t                         r_state;
  state_t                         w_state_n;
  logic [KCW-1:0]                 r_key_cnt;
  logic [DCW-1:0]                 r_data_cnt;
  logic [TCW-1:0]                 r_tmo;
  logic [WORD_W*KEY_WORDS-1:0]    r_key;
  logic [WORD_W*DATA_WORDS-1:0]   r_data;
  logic [127:0]                   r_res;
  logic                           r_err_ovf;
  logic                           r_err_tmo;

  logic w_acc;
  logic w_key_wr;
  logic w_data_wr;
  logic w_ovf;
  logic w_key_full_n;
  logic w_data_full_n;
  logic w_tmo_hit;

  assign w_acc     = wr_valid && (r_state == S_IDLE);
  assign w_key_wr  = w_acc &&  wr_sel && (r_key_cnt  != KEY_FULL);
  assign w_data_wr = w_acc && !wr_sel && (r_data_cnt != DATA_FULL);
  assign w_ovf     = w_acc && (wr_sel ? (r_key_cnt == KEY_FULL) : (r_data_cnt == DATA_FULL));
  // Fullness includes the word being accepted this cycle so START follows the last accept directly.
  assign w_key_full_n  = (r_key_cnt  == KEY_FULL)  || (w_key_wr  && (r_key_cnt  == KEY_LAST));
  assign w_data_full_n = (r_data_cnt == DATA_FULL) || (w_data_wr && (r_data_cnt == DATA_LAST));
  assign w_tmo_hit     = (r_state == S_WAIT) && !core_valid && (r_tmo == TMO_LAST);

  assign core_key  = r_key;
  assign core_data = r_data;
  assign res_data  = r_res;
  assign err_ovf   = r_err_ovf;
  assign err_tmo   = r_err_tmo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_n;
  end

  always_comb begin
    w_state_n  = r_state;
    wr_ready   = 1'b0;
    core_start = 1'b0;
    res_valid  = 1'b0;
    busy       = 1'b0;
    case (r_state)
      S_IDLE: begin
        wr_ready = 1'b1;
        if (w_key_full_n && w_data_full_n) w_state_n = S_START;
      end
      S_START: begin
        core_start = 1'b1;
        busy       = 1'b1;
        w_state_n  = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (core_valid)     w_state_n = S_OUT;
        else if (w_tmo_hit) w_state_n = S_IDLE;
      end
      S_OUT: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        if (res_ready) w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
    if (clr) w_state_n = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_cnt  <= '0;
      r_data_cnt <= '0;
      r_tmo      <= '0;
      r_key      <= '0;
      r_data     <= '0;
      r_res      <= '0;
      r_err_ovf  <= 1'b0;
      r_err_tmo  <= 1'b0;
    end else if (clr) begin
      r_key_cnt  <= '0;
      r_data_cnt <= '0;
      r_err_ovf  <= 1'b0;
      r_err_tmo  <= 1'b0;
`ifdef LOADSEQ_KEY_ZEROIZE_EN
      r_key      <= '0;
      r_data     <= '0;
`endif
    end else begin
      for (int unsigned i = 0; i < KEY_WORDS; i++) begin
        if (w_key_wr && (r_key_cnt == KCW'(i))) r_key[i*WORD_W +: WORD_W] <= wr_data;
      end
      for (int unsigned i = 0; i < DATA_WORDS; i++) begin
        if (w_data_wr && (r_data_cnt == DCW'(i))) r_data[i*WORD_W +: WORD_W] <= wr_data;
      end
      if (w_key_wr)  r_key_cnt  <= r_key_cnt + 1'b1;
      if (w_data_wr) r_data_cnt <= r_data_cnt + 1'b1;
      if (w_ovf)     r_err_ovf  <= 1'b1;

      case (r_state)
        S_START: r_tmo <= '0;
        S_WAIT: begin
          r_tmo <= r_tmo + 1'b1;
          if (core_valid) begin
            r_res <= core_result;
`ifdef LOADSEQ_KEY_ZEROIZE_EN
            r_key <= '0;
`endif
          end else if (w_tmo_hit) begin
            r_err_tmo  <= 1'b1;
            r_key_cnt  <= '0;
            r_data_cnt <= '0;
`ifdef LOADSEQ_KEY_ZEROIZE_EN
            r_key      <= '0;
`endif
          end
        end
        S_OUT: begin
          if (res_ready) begin
            r_key_cnt  <= '0;
            r_data_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_crypto_load_sequencer.sv
// Scoreboard bench for crypto_load_sequencer: random block loads against a word-array model,
// with directed overflow, timeout, boundary-capture, clear and asynchronous-reset scenarios.
module tb_crypto_load_sequencer;

  localparam int TMO = 24;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wr_valid;
  logic         wr_ready;
  logic         wr_sel;
  logic [31:0]  wr_data;
  logic         clr;
  logic         core_start;
  logic [255:0] core_key;
  logic [127:0] core_data;
  logic         core_valid;
  logic [127:0] core_result;
  logic         res_valid;
  logic         res_ready;
  logic [127:0] res_data;
  logic         busy;
  logic         err_ovf;
  logic         err_tmo;

  crypto_load_sequencer #(
    .WORD_W(32), .KEY_WORDS(8), .DATA_WORDS(4), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_sel(wr_sel),
    .wr_data(wr_data), .clr(clr), .core_start(core_start), .core_key(core_key),
    .core_data(core_data), .core_valid(core_valid), .core_result(core_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy),
    .err_ovf(err_ovf), .err_tmo(err_tmo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: word arrays, fill counts, sticky flags.
  logic [31:0]  km[8];
  logic [31:0]  dm[4];
  int           kc, dc;
  bit           ovf_m, tmo_m;
  logic [127:0] last_res;

  typedef struct {
    logic [255:0] k;
    logic [127:0] d;
    int           c;
  } start_t;
  start_t       sq[$];
  logic [127:0] rq[$];

  function automatic logic [255:0] mkey();
    logic [255:0] v = '0;
    for (int i = 0; i < 8; i++) v = v | (256'(km[i]) << (32 * i));
    return v;
  endfunction

  function automatic logic [127:0] mdata();
    logic [127:0] v = '0;
    for (int i = 0; i < 4; i++) v = v | (128'(dm[i]) << (32 * i));
    return v;
  endfunction

  task automatic model_zero_all();
    for (int i = 0; i < 8; i++) km[i] = '0;
    for (int i = 0; i < 4; i++) dm[i] = '0;
    kc = 0; dc = 0; ovf_m = 0; tmo_m = 0; last_res = '0;
  endtask

  task automatic model_leave_wait();
    kc = 0; dc = 0;
`ifdef LOADSEQ_KEY_ZEROIZE_EN
    for (int i = 0; i < 8; i++) km[i] = '0;
`endif
  endtask

  // Monitor: checks every start pulse and every presented result against the queues.
  always @(negedge clk) begin
    if (rst_n && core_start) begin
      n_checks++;
      if (sq.size() == 0) begin
        n_fail++;
        $display("FAIL start_q actual=unexpected_start required=no_start (t=%0t)", $time);
      end else begin
        start_t e;
        e = sq.pop_front();
        chk("start_key", core_key, e.k);
        chk("start_data", 256'(core_data), 256'(e.d));
        chk("start_cycle", 256'(cyc), 256'(e.c));
      end
    end
    if (rst_n && res_valid) begin
      n_checks++;
      if (rq.size() == 0) begin
        n_fail++;
        $display("FAIL res_q actual=unexpected_res_valid required=idle (t=%0t)", $time);
      end else begin
        chk("res_data", 256'(res_data), 256'(rq[0]));
        if (res_ready) void'(rq.pop_front());
      end
    end
  end

  task automatic put(input bit sel, input logic [31:0] d);
    bit full_before;
    full_before = (kc == 8) && (dc == 4);
    wr_valid = 1'b1; wr_sel = sel; wr_data = d;
    @(posedge clk); #1;
    wr_valid = 1'b0;
    if (sel) begin
      if (kc < 8) begin km[kc] = d; kc++; end else ovf_m = 1;
    end else begin
      if (dc < 4) begin dm[dc] = d; dc++; end else ovf_m = 1;
    end
    if (!full_before && kc == 8 && dc == 4) sq.push_back('{mkey(), mdata(), cyc});
  endtask

  task automatic load_random();
    bit sel;
    while (kc < 8 || dc < 4) begin
      if (kc >= 8)      sel = 0;
      else if (dc >= 4) sel = 1;
      else              sel = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      put(sel, $urandom);
    end
  endtask

  task automatic wait_start();
    int n = 0;
    @(negedge clk);
    while (!core_start && n < 6) begin @(negedge clk); n++; end
    chk("start_seen", 256'(core_start), 256'(1));
  endtask

  // From the START-cycle negedge: answer after d WAIT cycles, hold the result h cycles.
  task automatic run_core(input int d, input int h);
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk); #1;
    repeat (d) begin @(posedge clk); #1; end
    core_valid = 1'b1; core_result = r;
    rq.push_back(r);
    @(posedge clk); #1;
    core_valid = 1'b0; core_result = '0;
    model_leave_wait();
    last_res = r;
    repeat (h) begin
      chk("res_hold_valid", 256'(res_valid), 256'(1));
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("post_res_wr_ready", 256'(wr_ready), 256'(1));
    chk("post_res_valid", 256'(res_valid), 256'(0));
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    ovf_m = 0; tmo_m = 0; kc = 0; dc = 0;
`ifdef LOADSEQ_KEY_ZEROIZE_EN
    for (int i = 0; i < 8; i++) km[i] = '0;
    for (int i = 0; i < 4; i++) dm[i] = '0;
`endif
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, "_err_ovf"}, 256'(err_ovf), 256'(ovf_m));
    chk({tag, "_err_tmo"}, 256'(err_tmo), 256'(tmo_m));
  endtask

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
  endtask

  initial begin
    #400000;
    n_fail++;
    $display("FAIL watchdog actual=timeout required=finish");
    summary();
    $fatal(1);
  end

  initial begin
    int c0, n;
    rst_n = 1'b0; wr_valid = 0; wr_sel = 0; wr_data = '0; clr = 0;
    core_valid = 0; core_result = '0; res_ready = 0;
    model_zero_all();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_ready", 256'(wr_ready), 256'(1));
    chk("rst_busy", 256'({busy, core_start, res_valid, err_ovf, err_tmo}), 256'(0));
    chk("rst_key", core_key, 256'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed block: key 0..7, data A0..A3.
    for (int i = 0; i < 8; i++) put(1'b1, 32'(i));
    for (int i = 0; i < 4; i++) put(1'b0, 32'hA0 + 32'(i));
    wait_start();
    chk("key_low_word", 256'(core_key[31:0]), 256'(0));
    chk("key_high_word", 256'(core_key[255:224]), 256'(7));
    chk("data_high_word", 256'(core_data[127:96]), 256'(32'hA3));
    run_core(3, 5);

    // Random blocks.
    for (int b = 0; b < 4; b++) begin
      load_random();
      wait_start();
      run_core($urandom_range(0, TMO - 1), $urandom_range(0, 4));
      chk_flags("rand");
    end

    // Overflow: ninth key word dropped, flag sticky until clr.
    for (int i = 0; i < 8; i++) put(1'b1, $urandom);
    put(1'b1, 32'hBAD0BAD0);
    chk("ovf_set", 256'(err_ovf), 256'(1));
    chk("ovf_key_unchanged", core_key, mkey());
    for (int i = 0; i < 4; i++) put(1'b0, $urandom);
    wait_start();
    run_core(2, 1);
    chk_flags("ovf_persist");
    do_clr();
    chk_flags("after_clr1");

    // Timeout: core never answers.
    load_random();
    wait_start();
    c0 = cyc;
    n = 0;
    while (!err_tmo && n < 40) begin @(negedge clk); n++; end
    tmo_m = 1;
    model_leave_wait();
    chk("tmo_cycle", 256'(cyc), 256'(c0 + TMO + 1));
    chk("tmo_res_valid", 256'(res_valid), 256'(0));
    chk("tmo_idle", 256'(wr_ready), 256'(1));
    chk("tmo_key", core_key, mkey());
    chk_flags("tmo");
    @(posedge clk); #1;
    do_clr();
    chk_flags("after_clr2");
    chk("clr_key", core_key, mkey());
    chk("clr_data", 256'(core_data), 256'(mdata()));

    // Capture on the last possible WAIT cycle wins over the timeout.
    load_random();
    wait_start();
    run_core(TMO - 1, 2);
    chk_flags("late_capture");

    // core_valid outside WAIT is ignored.
    core_valid = 1'b1; core_result = '1;
    @(posedge clk); #1;
    core_valid = 1'b0; core_result = '0;
    chk("idle_core_valid_res", 256'(res_valid), 256'(0));
    chk("idle_core_valid_data", 256'(res_data), 256'(last_res));

    // Asynchronous reset in the middle of WAIT.
    load_random();
    wait_start();
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    sq.delete(); rq.delete();
    model_zero_all();
    chk("arst_wr_ready", 256'(wr_ready), 256'(1));
    chk("arst_outs", 256'({busy, core_start, res_valid, err_ovf, err_tmo}), 256'(0));
    chk("arst_key", core_key, 256'(0));
    chk("arst_data", 256'(core_data), 256'(0));
    chk("arst_res", 256'(res_data), 256'(0));
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) put(1'b1, $urandom);
    for (int i = 0; i < 3; i++) put(1'b0, $urandom);
    repeat (3) begin
      @(negedge clk);
      chk("no_early_start", 256'(core_start), 256'(0));
    end
    #1;
    put(1'b0, $urandom);
    wait_start();
    run_core($urandom_range(0, 10), 1);

    for (int b = 0; b < 3; b++) begin
      load_random();
      wait_start();
      run_core($urandom_range(0, TMO - 1), $urandom_range(0, 3));
    end

    repeat (2) @(posedge clk);
    chk("start_q_drained", 256'(sq.size()), 256'(0));
    chk("res_q_drained", 256'(rq.size()), 256'(0));
    summary();
    $finish;
  end

endmodule
